vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel position, syncs, display enable and frame markers.
// The generator drives it through the master modport; pixel pipelines and
// sync output stages listen through the slave modport.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX,
        output DrawY,
        output hs,
        output vs,
        output blank,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        input DrawX,
        input DrawY,
        input hs,
        input vs,
        input blank,
        input line_start,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A free-running column/line counter pair walks the whole raster, including
// porches and sync. Every output is decoded from the same (hc, vc) pair and
// registered in a single stage. All outputs therefore stay mutually aligned
// and trail the counters by exactly one pixel clock.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Raster position and completed-frame count
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] frameCnt_q, frameCnt_d;
    logic       hWrap, vWrap;

    // Registered, mutually aligned outputs
    logic [9:0] drawX_q, drawX_d;
    logic [9:0] drawY_q, drawY_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       lineStart_q, lineStart_d;
    logic       frameStart_q, frameStart_d;
    logic [7:0] frameCount_q, frameCount_d;

    // Counter advance: columns every cycle, lines on column wrap, frames on
    // line wrap; the >= compares keep the counters in range under any upset.
    always_comb begin
        hWrap      = (hc_q >= H_LAST);
        vWrap      = (vc_q >= V_LAST);
        hc_d       = hWrap ? 10'd0 : hc_q + 10'd1;
        vc_d       = vc_q;
        frameCnt_d = frameCnt_q;
        if (hWrap) begin
            vc_d = vWrap ? 10'd0 : vc_q + 10'd1;
            if (vWrap) begin
                frameCnt_d = frameCnt_q + 8'd1;
            end
        end
    end

    // Output decode from the current counter pair; sync pulses are active low
    // and vsync spans whole lines because it depends on vc only.
    always_comb begin
        drawX_d      = hc_q;
        drawY_d      = vc_q;
        hs_d         = ~((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
        vs_d         = ~((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));
        blank_d      = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
        lineStart_d  = (hc_q == 10'd0);
        frameStart_d = (hc_q == 10'd0) && (vc_q == 10'd0);
        frameCount_d = frameCnt_q;
    end

    // Counter state, cleared immediately when reset_n drops
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q       <= 10'd0;
            vc_q       <= 10'd0;
            frameCnt_q <= 8'd0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Output register stage; idle values are syncs high, blanking, no pulses
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            drawX_q      <= 10'd0;
            drawY_q      <= 10'd0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_q      <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            frameCount_q <= 8'd0;
        end else begin
            drawX_q      <= drawX_d;
            drawY_q      <= drawY_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_q      <= blank_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign vga_o.DrawX       = drawX_q;
    assign vga_o.DrawY       = drawY_q;
    assign vga_o.hs          = hs_q;
    assign vga_o.vs          = vs_q;
    assign vga_o.blank       = blank_q;
    assign vga_o.line_start  = lineStart_q;
    assign vga_o.frame_start = frameStart_q;
    assign vga_o.frame_count = frameCount_q;

endmodule
